// File: rtl/cursor.sv
// Text-mode cursor controller: blink generator, cursor position tracking from key events,
// and registered cursor-cell hit flag. Optional macro CURSOR_HOLD_EN keeps the cursor solid after typing.
module cursor #(
    parameter int COLS       = 70,
    parameter int ROWS       = 30,
    parameter int BLINK_HALF = 12500000,
    parameter int PROMPT_X   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       flash_on,
    input  logic       key_valid,
    input  logic [7:0] key_ascii,
    input  logic       is_dir,
    output logic [6:0] cur_x,
    output logic [4:0] cur_y,
    output logic       scroll,
    input  logic [6:0] scan_x,
    input  logic [4:0] scan_y,
    output logic       cursor_hit
);

    localparam int              CW       = $clog2(BLINK_HALF);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(BLINK_HALF - 1);
    localparam logic [6:0]      X_MAX    = 7'(COLS - 1);
    localparam logic [6:0]      X_PROMPT = 7'(PROMPT_X);
    localparam logic [4:0]      Y_MAX    = 5'(ROWS - 1);

    logic [CW-1:0] r_cnt;
    logic          r_flash;
    logic [6:0]    r_x;
    logic [4:0]    r_y;
    logic          r_scroll;
    logic          r_hit;

    logic [6:0]    w_nx;
    logic [4:0]    w_ny;
    logic          w_scroll;

    // Next cursor position for the current key event; Enter and Backspace ignore is_dir.
    always_comb begin
        w_nx     = r_x;
        w_ny     = r_y;
        w_scroll = 1'b0;
        if (key_valid) begin
            if (key_ascii == 8'h0D) begin
                w_nx = X_PROMPT;
                if (r_y < Y_MAX) w_ny = r_y + 5'd1;
                else             w_scroll = 1'b1;
            end else if (key_ascii == 8'h08) begin
                if (r_x != 7'd0) begin
                    w_nx = r_x - 7'd1;
                end else if (r_y != 5'd0) begin
                    w_nx = X_MAX;
                    w_ny = r_y - 5'd1;
                end
            end else if (is_dir) begin
                case (key_ascii)
                    8'h32:   if (r_y < Y_MAX)  w_ny = r_y + 5'd1;
                    8'h34:   if (r_x != 7'd0)  w_nx = r_x - 7'd1;
                    8'h36:   if (r_x < X_MAX)  w_nx = r_x + 7'd1;
                    8'h38:   if (r_y != 5'd0)  w_ny = r_y - 5'd1;
                    default: ;
                endcase
            end else if (key_ascii >= 8'h20 && key_ascii <= 8'h7E) begin
                if (r_x < X_MAX) begin
                    w_nx = r_x + 7'd1;
                end else begin
                    w_nx = 7'd0;
                    if (r_y < Y_MAX) w_ny = r_y + 5'd1;
                    else             w_scroll = 1'b1;
                end
            end
        end
    end

`ifdef CURSOR_HOLD_EN
    logic w_change;
    assign w_change = (w_nx != r_x) || (w_ny != r_y) || w_scroll;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_flash <= 1'b0;
`ifdef CURSOR_HOLD_EN
        end else if (w_change) begin
            r_cnt   <= '0;
            r_flash <= 1'b1;
`endif
        end else if (r_cnt == CNT_MAX) begin
            r_cnt   <= '0;
            r_flash <= ~r_flash;
        end else begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // Hit uses the pre-edge position and blink phase, giving one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= X_PROMPT;
            r_y      <= 5'd0;
            r_scroll <= 1'b0;
            r_hit    <= 1'b0;
        end else begin
            r_x      <= w_nx;
            r_y      <= w_ny;
            r_scroll <= w_scroll;
            r_hit    <= (scan_x == r_x) && (scan_y == r_y) && r_flash;
        end
    end

    assign flash_on   = r_flash;
    assign cur_x      = r_x;
    assign cur_y      = r_y;
    assign scroll     = r_scroll;
    assign cursor_hit = r_hit;

endmodule

// File: tb/tb_cursor.sv
// Directed self-checking bench for cursor (COLS=70, ROWS=30, BLINK_HALF=4, PROMPT_X=2).
module tb_cursor;

  logic       clk;
  logic       rst_n;
  logic       flash_on;
  logic       key_valid;
  logic [7:0] key_ascii;
  logic       is_dir;
  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic       scroll;
  logic [6:0] scan_x;
  logic [4:0] scan_y;
  logic       cursor_hit;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  cursor #(
    .COLS(70),
    .ROWS(30),
    .BLINK_HALF(4),
    .PROMPT_X(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flash_on(flash_on),
    .key_valid(key_valid),
    .key_ascii(key_ascii),
    .is_dir(is_dir),
    .cur_x(cur_x),
    .cur_y(cur_y),
    .scroll(scroll),
    .scan_x(scan_x),
    .scan_y(scan_y),
    .cursor_hit(cursor_hit)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rising edges since the last reset release; drives the blink model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic flash_model(input int n);
    return ((n / 4) % 2) == 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(cur_x), 32'(x));
    check({tag, "_y"}, 32'(cur_y), 32'(y));
  endtask

  // driver tasks
  task automatic press(input logic [7:0] a, input logic d);
    key_ascii = a;
    is_dir    = d;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    is_dir    = 1'b0;
    key_ascii = 8'h00;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_ascii = 8'h00;
    is_dir    = 1'b0;
    scan_x    = 7'd127;
    scan_y    = 5'd31;

    repeat (2) @(negedge clk);
    check_pos("rst_pos", 2, 0);
    check("rst_flash", 32'(flash_on), 0);
    check("rst_scroll", 32'(scroll), 0);
    check("rst_hit", 32'(cursor_hit), 0);
    rst_n = 1'b1;

    // free-running blink: first rise 4 edges after release, fall at 8
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("blink", 32'(flash_on), ((i >= 4) && (i < 8)) ? 1 : 0);
    end
    check_pos("after_rst", 2, 0);

    // printable run to end of line, then wrap
    for (int i = 0; i < 67; i++) press(8'h41, 1'b0);
    check_pos("type_eol", 69, 0);
    check("type_eol_scroll", 32'(scroll), 0);
    press(8'h41, 1'b0);
    check_pos("type_wrap", 0, 1);
    check("type_wrap_scroll", 32'(scroll), 0);

    press(8'h08, 1'b0);
    check_pos("bs_line_back", 69, 0);
    press(8'h41, 1'b0);
    press(8'h38, 1'b1);
    check_pos("up_to_origin", 0, 0);
    press(8'h08, 1'b0);
    check_pos("bs_origin", 0, 0);
    press(8'h34, 1'b1);
    check_pos("left_sat", 0, 0);
    press(8'h38, 1'b1);
    check_pos("up_sat", 0, 0);
    press(8'h36, 1'b1);
    check_pos("right1", 1, 0);
    press(8'h36, 1'b1);
    press(8'h36, 1'b1);
    check_pos("right3", 3, 0);
    press(8'h08, 1'b0);
    check_pos("bs_3_0", 2, 0);
    press(8'h41, 1'b1);
    check_pos("dir_other", 2, 0);
    press(8'h07, 1'b0);
    press(8'h7F, 1'b0);
    check_pos("nonprint", 2, 0);
    press(8'h20, 1'b0);
    press(8'h7E, 1'b0);
    check_pos("print_edges", 4, 0);

    // backspace across a line boundary from column 0
    for (int i = 0; i < 5; i++) press(8'h0D, 1'b0);
    check_pos("enter5", 2, 5);
    press(8'h34, 1'b1);
    press(8'h34, 1'b1);
    press(8'h08, 1'b0);
    check_pos("bs_0_5", 69, 4);

    // Enter down to the last row and the scroll boundary
    for (int i = 0; i < 24; i++) press(8'h0D, 1'b0);
    check_pos("enter_r28", 2, 28);
    press(8'h0D, 1'b0);
    check_pos("enter_r29", 2, 29);
    check("enter_r29_scroll", 32'(scroll), 0);
    press(8'h32, 1'b1);
    check_pos("down_sat", 2, 29);
    press(8'h0D, 1'b0);
    check_pos("enter_last", 2, 29);
    check("enter_last_scroll", 32'(scroll), 1);
    idle();
    check("scroll_one_cycle", 32'(scroll), 0);
    press(8'h0D, 1'b1);
    check("enter_dir_scroll", 32'(scroll), 1);
    check_pos("enter_dir", 2, 29);

    // printable wrap on the last row scrolls
    for (int i = 0; i < 67; i++) press(8'h41, 1'b0);
    check_pos("type_eol_last", 69, 29);
    check("type_eol_last_scroll", 32'(scroll), 0);
    press(8'h41, 1'b0);
    check_pos("type_wrap_last", 0, 29);
    check("type_wrap_last_scroll", 32'(scroll), 1);
    idle();
    check("wrap_scroll_clear", 32'(scroll), 0);

    // cursor hit against the blink model
    for (int i = 0; i < 26; i++) press(8'h38, 1'b1);
    for (int i = 0; i < 5; i++) press(8'h36, 1'b1);
    check_pos("hit_pos", 5, 3);
    check("hit_off_scan", 32'(cursor_hit), 0);
    scan_x = 7'd5;
    scan_y = 5'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hit_follow", 32'(cursor_hit), 32'(flash_model(cyc - 1)));
      check("flash_free", 32'(flash_on), 32'(flash_model(cyc)));
    end
    scan_x = 7'd6;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hit_miss", 32'(cursor_hit), 0);
    end

    // asynchronous reset mid-run, then key press right after release
    rst_n = 1'b0;
    #1;
    check_pos("async_rst", 2, 0);
    check("async_rst_flash", 32'(flash_on), 0);
    check("async_rst_hit", 32'(cursor_hit), 0);
    @(negedge clk);
    rst_n = 1'b1;
    press(8'h41, 1'b0);
    check_pos("post_rst_key", 3, 0);
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) @(negedge clk);
`ifdef CURSOR_HOLD_EN
      check("hold_flash", 32'(flash_on), (i <= 4) ? 1 : 0);
`else
      check("free_flash", 32'(flash_on), (i == 4 || i == 5) ? 1 : 0);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
